// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one fixed-latency synchronous memory.
// Define MEM_ARB_ROUND_ROBIN_EN to replace data-first priority with round-robin on conflicts.
module mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_d
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_re_q, mem_re_d;
    logic          busy_q, busy_d;
    logic          grant_d_q, grant_d_d;
    logic          pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          last_grant_q, last_grant_d;

    // On a conflict the port that did not win last time goes first.
    assign pick_data = d_req && (!if_req || !last_grant_q);
`else
    assign pick_data = d_req;
`endif

    // mem_addr doubles as the latched transaction address; it is only reloaded on a grant.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d_d   = grant_d_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_d_d  = pick_data;
                    we_d       = pick_data && d_we;
                    mem_addr_d = pick_data ? d_addr : if_addr;
                    if (pick_data && d_we) begin
                        mem_wdata_d = d_wdata;
                        mem_we_d    = 1'b1;
                    end else begin
                        mem_re_d = 1'b1;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = pick_data;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    d_ack_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (grant_d_q) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            grant_d_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            busy_q      <= busy_d;
            grant_d_q   <= grant_d_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;
    assign grant_d   = grant_d_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Drives two arbiters (MEM_LAT 1 and 4) with shared stimulus; each is checked every cycle
// against a transaction-schedule model and a memory model.
module tb_mem_arbiter;
    logic       clk;
    logic       reset;
    logic       if_req;
    logic [7:0] if_addr;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [7:0] init_val(input int a);
        case (a)
            8'h05:   return 8'h20;
            8'h10:   return 8'h3C;
            8'h33:   return 8'hC3;
            8'h44:   return 8'h5A;
            default: return 8'(a * 7 + 3);
        endcase
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 4;

        logic       if_ack, d_ack, mem_we, mem_re, busy, grant_d;
        logic [7:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

        mem_arbiter #(.MEM_LAT(LAT), .AW(8), .DW(8)) u_dut (
            .clk(clk), .reset(reset),
            .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_ack(d_ack), .d_rdata(d_rdata),
            .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
            .mem_rdata(mem_rdata), .busy(busy), .grant_d(grant_d)
        );

        // Memory macro: data valid LAT cycles after the mem_re cycle, garbage otherwise.
        logic [7:0] macro_mem [256];
        bit         macro_init = 1'b0;
        int         rd_cnt = 0;
        logic [7:0] rd_addr = 8'h00;
        bit         rd_pend = 1'b0;

        always @(posedge clk) begin
            if (!macro_init) begin
                for (int i = 0; i < 256; i++) macro_mem[i] = init_val(i);
                macro_init = 1'b1;
            end
            if (mem_we) macro_mem[mem_addr] = mem_wdata;
            if (mem_re) begin
                rd_cnt  = LAT - 1;
                rd_addr = mem_addr;
                rd_pend = 1'b1;
            end else if (rd_pend && rd_cnt > 0) begin
                rd_cnt--;
            end
            if (rd_pend && rd_cnt == 0) begin
                mem_rdata <= macro_mem[rd_addr];
                rd_pend = 1'b0;
            end else begin
                mem_rdata <= 8'($urandom);
            end
        end

        // Model: a granted transaction occupies relative cycles 1..len, ack on cycle len.
        logic [7:0] ref_mem [256];
        bit         ref_init = 1'b0;
        bit         act = 1'b0;
        int         rel = 0;
        int         len = 0;
        bit         m_port = 1'b0;
        bit         m_we = 1'b0;
        logic [7:0] m_addr = 8'h00;
        logic [7:0] m_wdata = 8'h00;
        bit         last_d = 1'b0;
        bit         win_d;
        logic       e_busy = 1'b0, e_re = 1'b0, e_we = 1'b0;
        logic       e_if_ack = 1'b0, e_d_ack = 1'b0, e_grant = 1'b0;
        logic [7:0] e_addr = 8'h00, e_wdata = 8'h00, e_if_rdata = 8'h00, e_d_rdata = 8'h00;

        always @(posedge clk) begin
            if (!ref_init) begin
                for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
                ref_init = 1'b1;
            end
            if (!reset) begin
                act = 1'b0; rel = 0; last_d = 1'b0;
                e_grant = 1'b0; e_addr = 8'h00; e_wdata = 8'h00;
                e_if_rdata = 8'h00; e_d_rdata = 8'h00;
            end else begin
                if (act) begin
                    if (rel == 1 && m_we) ref_mem[m_addr] = m_wdata;
                    rel++;
                    if (rel == len + 1) act = 1'b0;
                end else if (if_req || d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    win_d = d_req && (!if_req || !last_d);
`else
                    win_d = d_req;
`endif
                    act     = 1'b1;
                    rel     = 1;
                    m_port  = win_d;
                    m_we    = win_d && d_we;
                    m_addr  = win_d ? d_addr : if_addr;
                    m_wdata = d_wdata;
                    len     = m_we ? 2 : LAT + 2;
                    last_d  = win_d;
                    e_grant = win_d;
                    e_addr  = m_addr;
                    if (m_we) e_wdata = m_wdata;
                end
                if (act && rel == len && !m_we) begin
                    if (m_port) e_d_rdata = ref_mem[m_addr];
                    else e_if_rdata = ref_mem[m_addr];
                end
            end
            e_busy   = act;
            e_re     = act && rel == 1 && !m_we;
            e_we     = act && rel == 1 && m_we;
            e_if_ack = act && rel == len && !m_port;
            e_d_ack  = act && rel == len && m_port;
        end

        always @(posedge clk) begin
            #1;
            check1($sformatf("L%0d busy", LAT), busy, e_busy);
            check1($sformatf("L%0d mem_re", LAT), mem_re, e_re);
            check1($sformatf("L%0d mem_we", LAT), mem_we, e_we);
            check1($sformatf("L%0d if_ack", LAT), if_ack, e_if_ack);
            check1($sformatf("L%0d d_ack", LAT), d_ack, e_d_ack);
            check1($sformatf("L%0d grant_d", LAT), grant_d, e_grant);
            check8($sformatf("L%0d mem_addr", LAT), mem_addr, e_addr);
            check8($sformatf("L%0d mem_wdata", LAT), mem_wdata, e_wdata);
            check8($sformatf("L%0d if_rdata", LAT), if_rdata, e_if_rdata);
            check8($sformatf("L%0d d_rdata", LAT), d_rdata, e_d_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((g_inst[0].busy || g_inst[1].busy) && n < 40) begin
            step();
            n++;
        end
        n_total++;
        if (n < 40) n_pass++;
        else $display("[TB] FAIL idle timeout: busy0=%0b busy1=%0b after %0d cycles",
                      g_inst[0].busy, g_inst[1].busy, n);
    endtask

    task automatic apply_stimulus();
        // Reset held with a pending fetch, then released into a LAT=1 fetch of 0x05.
        reset = 1'b0; if_req = 1'b1; if_addr = 8'h05;
        d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check1("rst busy", g_inst[0].busy, 1'b0);
        check1("rst mem_re", g_inst[0].mem_re, 1'b0);
        check1("rst if_ack", g_inst[0].if_ack, 1'b0);
        @(negedge clk); reset = 1'b1;
        step();
        check1("fetch c1 mem_re", g_inst[0].mem_re, 1'b1);
        check8("fetch c1 mem_addr", g_inst[0].mem_addr, 8'h05);
        step(); step();
        check1("fetch c3 if_ack", g_inst[0].if_ack, 1'b1);
        check8("fetch c3 if_rdata", g_inst[0].if_rdata, 8'h20);
        @(negedge clk); if_req = 1'b0;
        wait_idle();

        // Data write
        @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 8'h80; d_wdata = 8'hA5;
        step();
        check1("wr c1 mem_we", g_inst[0].mem_we, 1'b1);
        check8("wr c1 mem_addr", g_inst[0].mem_addr, 8'h80);
        check8("wr c1 mem_wdata", g_inst[0].mem_wdata, 8'hA5);
        @(negedge clk); d_req = 1'b0; d_we = 1'b0;
        step();
        check1("wr c2 d_ack", g_inst[0].d_ack, 1'b1);
        check1("wr c2 mem_we", g_inst[0].mem_we, 1'b0);
        step();
        check1("wr c3 d_ack", g_inst[0].d_ack, 1'b0);
        wait_idle();

        // Conflict: data read of 0x10 vs fetch of 0x44, last grant was data
        @(negedge clk); if_req = 1'b1; if_addr = 8'h44; d_req = 1'b1; d_addr = 8'h10;
        step(); step(); step();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check1("rr c3 if_ack", g_inst[0].if_ack, 1'b1);
        check8("rr c3 if_rdata", g_inst[0].if_rdata, 8'h5A);
        check1("rr c3 grant_d", g_inst[0].grant_d, 1'b0);
        @(negedge clk); if_req = 1'b0;
        repeat (4) step();
        check1("rr c7 d_ack", g_inst[0].d_ack, 1'b1);
        check8("rr c7 d_rdata", g_inst[0].d_rdata, 8'h3C);
        check1("rr c7 grant_d", g_inst[0].grant_d, 1'b1);
        @(negedge clk); d_req = 1'b0;
`else
        check1("cf c3 d_ack", g_inst[0].d_ack, 1'b1);
        check8("cf c3 d_rdata", g_inst[0].d_rdata, 8'h3C);
        check1("cf c3 if_ack", g_inst[0].if_ack, 1'b0);
        @(negedge clk); d_req = 1'b0;
        repeat (4) step();
        check1("cf c7 if_ack", g_inst[0].if_ack, 1'b1);
        check8("cf c7 if_rdata", g_inst[0].if_rdata, 8'h5A);
        check1("cf c7 grant_d", g_inst[0].grant_d, 1'b0);
        @(negedge clk); if_req = 1'b0;
`endif
        wait_idle();

        // One-cycle data read pulse of 0x33: LAT=1 and LAT=4 latencies
        @(negedge clk); d_req = 1'b1; d_we = 1'b0; d_addr = 8'h33;
        step();
        check1("lat4 c1 mem_re", g_inst[1].mem_re, 1'b1);
        check8("lat4 c1 mem_addr", g_inst[1].mem_addr, 8'h33);
        @(negedge clk); d_req = 1'b0;
        step(); step();
        check1("drop c3 d_ack", g_inst[0].d_ack, 1'b1);
        check8("drop c3 d_rdata", g_inst[0].d_rdata, 8'hC3);
        step(); step();
        check1("lat4 c5 busy", g_inst[1].busy, 1'b1);
        check1("lat4 c5 d_ack", g_inst[1].d_ack, 1'b0);
        step();
        check1("lat4 c6 d_ack", g_inst[1].d_ack, 1'b1);
        check8("lat4 c6 d_rdata", g_inst[1].d_rdata, 8'hC3);
        step();
        check1("lat4 c7 busy", g_inst[1].busy, 1'b0);
        wait_idle();

        // Reset during the LAT=4 WAIT phase, fetch held across it
        @(negedge clk); if_req = 1'b1; if_addr = 8'h05;
        step(); step(); step();
        @(negedge clk); reset = 1'b0;
        #1;
        check1("abort busy0", g_inst[0].busy, 1'b0);
        check1("abort busy1", g_inst[1].busy, 1'b0);
        check1("abort if_ack1", g_inst[1].if_ack, 1'b0);
        step(); step();
        @(negedge clk); reset = 1'b1;
        repeat (6) step();
        check1("rearb c6 if_ack", g_inst[1].if_ack, 1'b1);
        check8("rearb c6 if_rdata", g_inst[1].if_rdata, 8'h20);
        @(negedge clk); if_req = 1'b0;
        wait_idle();

        // Fetch held through its ack starts a second fetch right after RESP
        @(negedge clk); if_req = 1'b1; if_addr = 8'h44;
        step(); step(); step();
        check1("hold c3 if_ack", g_inst[0].if_ack, 1'b1);
        step();
        check1("hold c4 busy", g_inst[0].busy, 1'b0);
        step();
        check1("hold c5 mem_re", g_inst[0].mem_re, 1'b1);
        @(negedge clk); if_req = 1'b0;
        step(); step();
        check1("hold c7 if_ack", g_inst[0].if_ack, 1'b1);
        check8("hold c7 if_rdata", g_inst[0].if_rdata, 8'h5A);
        wait_idle();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 199) != 0);
            if_req  = ($urandom_range(0, 2) == 0);
            d_req   = ($urandom_range(0, 2) == 0);
            d_we    = $urandom_range(0, 1) == 1;
            if_addr = 8'($urandom_range(0, 15));
            d_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d_wdata = 8'($urandom);
        end
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        wait_idle();
        step();
    endtask

    initial begin
        apply_stimulus();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 256x8 program/data memory between two requesters.
  - Instruction-fetch port: read-only, driven by the control unit in FETCH.
  - Data port: read/write, driven in EXEC for LDA/STA and operand reads.
- Sequences each access through a fixed-latency synchronous memory and returns data with a one-cycle ack pulse.
- Sits between the control unit and the memory macro; the only block that drives the memory's address, data and enable pins.

Parameters:
- MEM_LAT, 1: memory read latency in cycles from mem_re to valid mem_rdata. Legal range 1..7.
- AW, 8: address width.
- DW, 8: data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held until if_ack.
- if_addr  input  AW  fetch address (PC).
- if_ack  output  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  output  DW  fetched instruction byte.
- d_req  input  1  data request; held until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data (ACC).
- d_ack  output  1  one-cycle pulse on completion.
- d_rdata  output  DW  read data; valid with d_ack on reads.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_we  output  1  memory write strobe, one cycle.
- mem_re  output  1  memory read strobe, one cycle.
- mem_rdata  input  DW  memory read data.
- busy  output  1  high in any state other than IDLE.
- grant_d  output  1  source of the current or last transaction (1 = data, 0 = fetch).

Behaviour:
- All outputs are registered. Reset (reset=0) clears every output, the state, the wait counter and the captured request to 0 and forces IDLE.
- Reset asserted mid-transaction aborts the transaction: no ack is ever produced for it, and no mem_we is issued after reset asserts.
- State machine: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise arbitrate: fixed priority, data over fetch.
  - Latch addr, we and wdata from the winner, set grant_d, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive mem_addr from the latched address.
  - Read: mem_re=1, load wait counter with MEM_LAT-1, go to WAIT.
  - Write: mem_we=1, mem_wdata = latched wdata, go to RESP.
  - Strobes are low in every other state; mem_addr holds its last value.
- WAIT (MEM_LAT cycles):
  - Count down.
  - In the cycle the counter is 0, capture mem_rdata into the winner's rdata register and go to RESP.
- RESP (1 cycle):
  - Pulse the winner's ack, go to IDLE.
  - The loser's ack stays 0.
- Latency, counting the cycle in which req is sampled high in IDLE as cycle 0:
  - Read: ack in cycle MEM_LAT+2 (cycle 3 for MEM_LAT=1).
  - Write: ack in cycle 2.
  - Back-to-back: a request held or re-raised is sampled in the IDLE cycle after RESP. Maximum throughput is therefore one read per MEM_LAT+3 cycles.
- Requester rule: req must be deasserted in the cycle after ack, or it is treated as a new request.
- Req dropped before ack: the transaction still completes and ack still pulses; a write is still performed.
- Request inputs are sampled only in IDLE; changes to addr/wdata during a transaction are ignored.
- if_rdata and d_rdata hold their value until the next read for that port completes.
- A d_we request on the fetch port is not possible (the fetch port is read-only).
- Simultaneous if_req and d_req in IDLE: data wins; fetch waits and is served on the next IDLE.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests, the port not granted last wins.
  - A 1-bit last-grant register, reset 0 (fetch), updates on every grant.
  - A lone request is always granted immediately.
- Undefined: fixed priority, data over fetch. The last-grant register is not present.

Test Plan:
- Reset check: reset=0 for 3 cycles with if_req=1 -> all outputs 0, no mem_re. Release reset with if_addr=0x05, mem_rdata=0x20 at MEM_LAT=1 -> mem_re in cycle 1 with mem_addr=0x05; if_ack=1 and if_rdata=0x20 in cycle 3.
- Data write: d_req=1, d_we=1, d_addr=0x80, d_wdata=0xA5 -> mem_we=1, mem_addr=0x80, mem_wdata=0xA5 in cycle 1; d_ack in cycle 2; mem_we exactly one cycle.
- Conflict: if_req and d_req both raised in the same cycle, read at 0x10, memory returns 0x3C -> d_ack with d_rdata=0x3C first. Fetch then served, if_ack exactly MEM_LAT+3 cycles after d_ack, grant_d=0. With MEM_ARB_ROUND_ROBIN_EN defined, after a prior data grant the fetch port wins first.
- Latency sweep: MEM_LAT=4 read at 0x33 -> mem_re cycle 1; capture at end of cycle 5; ack cycle 6; busy high cycles 1..6.
- Reset mid-read: assert reset during WAIT -> no ack, busy=0 immediately. After release, a held if_req is re-arbitrated and completes normally.
- Early drop and hold: d_req pulsed for one cycle only -> d_ack still pulses at nominal latency. Then if_req held through its ack -> a second fetch begins in the cycle after RESP.
